// File: rtl/morra_scoreboard_if.sv
// Record stream from the Morra scoreboard to its consumer: valid/ready handshake
// carrying {esito[1:0], rounds[4:0]}.
interface morra_scoreboard_if;
    logic       rec_valid;
    logic       rec_ready;
    logic [6:0] rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/morra_scoreboard.sv
// Match scoreboard for the Morra game FSMD: counts rounds, tallies match outcomes
// and queues one {esito, rounds} record per finished match in a small FIFO.
module morra_scoreboard #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INIZIA,
    input  logic [1:0]         MANCHE,
    input  logic [1:0]         PARTITA,
    output logic [CNT_W-1:0]   VITTORIE_PRIMO,
    output logic [CNT_W-1:0]   VITTORIE_SECONDO,
    output logic [CNT_W-1:0]   PAREGGI,
    output logic [4:0]         MANCHE_GIOCATE,
    output logic               OVERFLOW,
    morra_scoreboard_if.master rec
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GIOCO = 2'd1,
        FINE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic       clr_rounds;
    logic       count_round;
    logic       end_match;
    logic [4:0] rounds_inc;
    logic [4:0] rounds_now;
    logic [6:0] new_rec;

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic          full, pop, push_ok;

    // ------------------------------------------------------------------ FSM
    // NOTE: state and every other register use non-blocking assignments so all
    // flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (INIZIA) begin
            state_nxt = GIOCO;
        end else begin
            case (state)
                GIOCO:   if (PARTITA != 2'b00) state_nxt = FINE;
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        clr_rounds  = 1'b0;
        count_round = 1'b0;
        end_match   = 1'b0;
        if (INIZIA) begin
            clr_rounds = 1'b1;
        end else if (state == GIOCO) begin
            count_round = (MANCHE != 2'b00);
            end_match   = (PARTITA != 2'b00);
        end
    end

    // --------------------------------------------------------- round count
    assign rounds_inc = (MANCHE_GIOCATE == 5'd31) ? 5'd31 : MANCHE_GIOCATE + 5'd1;
    assign rounds_now = count_round ? rounds_inc : MANCHE_GIOCATE;
    assign new_rec    = {PARTITA, rounds_now};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           MANCHE_GIOCATE <= '0;
        else if (clr_rounds)  MANCHE_GIOCATE <= '0;
        else if (count_round) MANCHE_GIOCATE <= rounds_inc;
    end

    // -------------------------------------------------------------- tallies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VITTORIE_PRIMO   <= '0;
            VITTORIE_SECONDO <= '0;
            PAREGGI          <= '0;
        end else if (end_match) begin
            case (PARTITA)
                2'b01: if (VITTORIE_PRIMO != '1)
                           VITTORIE_PRIMO <= VITTORIE_PRIMO + CNT_W'(1);
                2'b10: if (VITTORIE_SECONDO != '1)
                           VITTORIE_SECONDO <= VITTORIE_SECONDO + CNT_W'(1);
                2'b11: if (PAREGGI != '1)
                           PAREGGI <= PAREGGI + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------- record FIFO
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = rec.rec_valid && rec.rec_ready;
    assign push_ok    = end_match && (!full || pop);
    assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // NOTE: the storage array has no reset; rec_data/rec_valid are reset instead,
    // so no stale entry is ever presented.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= new_rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rec.rec_valid <= 1'b0;
            rec.rec_data  <= '0;
            OVERFLOW      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr        <= rd_ptr_nxt;
            count         <= count_nxt;
            rec.rec_valid <= (count_nxt != '0);
            // The head after this edge is the new record only when it lands alone.
            if (count_nxt == '0)
                rec.rec_data <= '0;
            else if (push_ok && (wr_ptr == rd_ptr_nxt))
                rec.rec_data <= new_rec;
            else
                rec.rec_data <= mem[rd_ptr_nxt];
            if (end_match && full && !pop) OVERFLOW <= 1'b1;
        end
    end

endmodule
